modbus_rtu_uart_rx: RTL and testbench

RS-485 UART byte receiver for the Modbus RTU master. It oversamples the asynchronous rx line with a clock-derived bit timer and deframes 8-bit characters (start, 8 data bits LSB-first, optional parity, 1 stop). It delivers each good byte with a one-cycle update_rx strobe to the RTU receive controller, which edge-detects it. It also flags parity and framing errors, blanks reception while the master drives the bus (DE), and signals the Modbus 3.5-character inter-frame gap.

---
 rtl/modbus_rtu_uart_rx.sv | 219 +++++++++++++++++++++
 tb/tb_modbus_rtu_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_uart_rx.sv
// Modbus RTU RS-485 byte receiver: mid-bit sampled 8-bit deframer with optional parity,
// error strobes, saturating error counter, DE blanking and 3.5-character gap detection.
module modbus_rtu_uart_rx #(
    parameter int clk_freq_MHz = 80,
    parameter int baud_rate    = 115200,
    parameter int parity_mode  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        DE,
    output logic [7:0]  byte_out,
    output logic        update_rx,
    output logic        parity_err,
    output logic        frame_err,
    output logic        frame_gap,
    output logic [15:0] err_cnt,
    output logic        busy
);

    localparam int          BIT_CLKS_I = (clk_freq_MHz * 1_000_000) / baud_rate;
    localparam logic [15:0] BIT_CLKS   = 16'(BIT_CLKS_I);
    localparam logic [15:0] HALF_CLKS  = 16'(BIT_CLKS_I / 2);
    localparam int          GAP_CLKS_I = (baud_rate > 19200) ? (1750 * clk_freq_MHz)
                                                             : ((77 * BIT_CLKS_I) / 2);
    localparam logic [23:0] GAP_CLKS   = 24'(GAP_CLKS_I);
    localparam logic [1:0]  PAR_MODE   = 2'(parity_mode);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    // Even/odd parity check of a received character; no parity always passes.
    function automatic logic parity_ok_f(input logic [7:0] data, input logic par_bit,
                                         input logic [1:0] mode);
        logic sum;
        sum = ^{data, par_bit};
        case (mode)
            2'd1:    parity_ok_f = ~sum;
            2'd2:    parity_ok_f = sum;
            default: parity_ok_f = 1'b1;
        endcase
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic        de_prev_r;
    logic [15:0] bit_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        par_ok_r;
    logic [23:0] gap_cnt_r;
    logic        gap_armed_r;
    logic        fall_s;
    logic        half_done_s;
    logic        bit_done_s;
    logic        gap_done_s;
    logic        good_s;
    logic        perr_s;
    logic        ferr_s;

    // An edge seen in the same cycle DE drops is bus turnaround, not a start bit.
    assign fall_s      = rx_prev_r & ~rx_sync_r & ~de_prev_r;
    assign half_done_s = (bit_cnt_r == (HALF_CLKS - 16'd1));
    assign bit_done_s  = (bit_cnt_r == (BIT_CLKS - 16'd1));
    assign gap_done_s  = gap_armed_r && (gap_cnt_r == (GAP_CLKS - 24'd1))
                         && (state_r == IDLE) && !DE;

    // Line synchronizer and edge-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            de_prev_r <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            de_prev_r <= DE;
        end
    end

    // Next-state and strobe decode for the deframing FSM.
    always_comb begin
        next_state_s = state_r;
        good_s       = 1'b0;
        perr_s       = 1'b0;
        ferr_s       = 1'b0;
        if (DE) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) next_state_s = START;
                    else        next_state_s = IDLE;
                end
                START: begin
                    if (half_done_s) next_state_s = rx_sync_r ? IDLE : DATA;
                    else             next_state_s = START;
                end
                DATA: begin
                    if (bit_done_s && (bit_idx_r == 3'd7))
                        next_state_s = (PAR_MODE != 2'd0) ? PARITY : STOP;
                    else
                        next_state_s = DATA;
                end
                PARITY: begin
                    if (bit_done_s) next_state_s = STOP;
                    else            next_state_s = PARITY;
                end
                STOP: begin
                    if (bit_done_s) begin
                        if (!rx_sync_r) begin
                            ferr_s       = 1'b1;
                            next_state_s = WAIT_HIGH;
                        end else if (par_ok_r) begin
                            good_s       = 1'b1;
                            next_state_s = IDLE;
                        end else begin
                            perr_s       = 1'b1;
                            next_state_s = IDLE;
                        end
                    end else begin
                        next_state_s = STOP;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync_r) next_state_s = IDLE;
                    else           next_state_s = WAIT_HIGH;
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // State register, bit timer and character shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            par_ok_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if ((next_state_s != state_r) || bit_done_s ||
                (state_r == IDLE) || (state_r == WAIT_HIGH))
                bit_cnt_r <= 16'd0;
            else
                bit_cnt_r <= bit_cnt_r + 16'd1;
            if ((state_r == START) && (next_state_s == DATA)) begin
                bit_idx_r <= 3'd0;
                par_ok_r  <= 1'b1;
            end
            if ((state_r == DATA) && bit_done_s) begin
                shift_r   <= {rx_sync_r, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if ((state_r == PARITY) && bit_done_s)
                par_ok_r <= parity_ok_f(shift_r, rx_sync_r, PAR_MODE);
        end
    end

    // Registered strobes, delivered byte, error counter and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_out   <= 8'h00;
            update_rx  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_gap  <= 1'b0;
            err_cnt    <= 16'd0;
            busy       <= 1'b0;
        end else begin
            update_rx  <= good_s;
            parity_err <= perr_s;
            frame_err  <= ferr_s;
            frame_gap  <= gap_done_s;
            busy       <= (next_state_s != IDLE);
            if (good_s)
                byte_out <= shift_r;
            if ((perr_s || ferr_s) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end

    // Inter-frame gap timer: armed only by a good byte, one pulse per arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt_r   <= 24'd0;
            gap_armed_r <= 1'b0;
        end else if (DE) begin
            gap_cnt_r   <= 24'd0;
            gap_armed_r <= 1'b0;
        end else if (good_s) begin
            gap_cnt_r   <= 24'd0;
            gap_armed_r <= 1'b1;
        end else if (state_r != IDLE) begin
            gap_cnt_r <= 24'd0;
        end else if (gap_done_s) begin
            gap_cnt_r   <= 24'd0;
            gap_armed_r <= 1'b0;
        end else if (gap_armed_r) begin
            gap_cnt_r <= gap_cnt_r + 24'd1;
        end else begin
            gap_cnt_r <= 24'd0;
        end
    end

endmodule

// File: tb/tb_modbus_rtu_uart_rx.sv
// Directed self-checking bench for modbus_rtu_uart_rx, run at a reduced clock
// (8 MHz, 115200 baud, even parity) so gap scenarios stay short.
module tb_modbus_rtu_uart_rx;

    localparam int CLK_MHZ = 8;
    localparam int BAUD    = 115200;
    localparam int PMODE   = 1;
    localparam int BIT     = 69;      // 8e6 / 115200 = 69.44, truncated
    localparam int HALF    = 34;
    localparam int GAP     = 14000;   // 1750 * 8
    localparam int LAT     = 2 + 10 * BIT + HALF;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        DE;
    logic [7:0]  byte_out;
    logic        update_rx;
    logic        parity_err;
    logic        frame_err;
    logic        frame_gap;
    logic [15:0] err_cnt;
    logic        busy;

    int cyc = 0;
    int n_upd = 0, n_perr = 0, n_ferr = 0, n_gap = 0;
    int upd_cyc = 0, gap_cyc = 0, start_cyc = 0;
    int n_chk = 0, n_fail = 0;
    int u0, u1, g0;

    modbus_rtu_uart_rx #(
        .clk_freq_MHz(CLK_MHZ),
        .baud_rate   (BAUD),
        .parity_mode (PMODE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .DE        (DE),
        .byte_out  (byte_out),
        .update_rx (update_rx),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .frame_gap (frame_gap),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (update_rx) begin n_upd++; upd_cyc = cyc; end
        if (parity_err) n_perr++;
        if (frame_err) n_ferr++;
        if (frame_gap) begin n_gap++; gap_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_chk++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BIT);
        end
        rx = p;
        tick(BIT);
        rx = stop;
        tick(BIT);
        rx = 1'b1;
        tick(4);
    endtask

    initial begin
        rx = 1'b1; DE = 1'b0; reset = 1'b1;
        tick(5);
        check("rst_byte_out", 32'(byte_out), 32'h00);
        check("rst_update_rx", 32'(update_rx), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(3);
        check("idle_parity_err", 32'(parity_err), 32'h0);
        check("idle_frame_err", 32'(frame_err), 32'h0);
        check("idle_frame_gap", 32'(frame_gap), 32'h0);

        // Good byte 0x11, even parity bit 0
        u0 = n_upd;
        send(8'h11, 1'b0, 1'b1);
        tick(10);
        check("good_byte", 32'(byte_out), 32'h11);
        check("good_upd_cnt", 32'(n_upd - u0), 32'd1);
        check_rng("good_latency", upd_cyc - start_cyc, LAT - 3, LAT + 3);
        check("good_no_perr", 32'(n_perr), 32'd0);
        check("good_no_ferr", 32'(n_ferr), 32'd0);
        check("good_err_cnt", 32'(err_cnt), 32'd0);

        // Start glitch
        rx = 1'b0;
        tick(10);
        check("glitch_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        tick(HALF + 10);
        check("glitch_idle", 32'(busy), 32'h0);
        check("glitch_no_upd", 32'(n_upd - u0), 32'd1);
        send(8'hA5, 1'b0, 1'b1);
        tick(10);
        check("after_glitch_byte", 32'(byte_out), 32'hA5);
        check("after_glitch_upd", 32'(n_upd - u0), 32'd2);

        // Parity error: 0x03 needs parity 0, send 1
        send(8'h03, 1'b1, 1'b1);
        tick(10);
        check("perr_pulse", 32'(n_perr), 32'd1);
        check("perr_byte_kept", 32'(byte_out), 32'hA5);
        check("perr_err_cnt", 32'(err_cnt), 32'd1);
        check("perr_no_upd", 32'(n_upd - u0), 32'd2);

        // Break
        rx = 1'b0;
        tick(20 * BIT);
        check("break_busy", 32'(busy), 32'h1);
        check("break_ferr", 32'(n_ferr), 32'd1);
        rx = 1'b1;
        tick(10);
        check("break_released", 32'(busy), 32'h0);
        check("break_err_cnt", 32'(err_cnt), 32'd2);
        check("break_no_upd", 32'(n_upd - u0), 32'd2);
        check("break_no_perr", 32'(n_perr), 32'd1);
        send(8'h10, 1'b1, 1'b1);
        tick(10);
        check("after_break_byte", 32'(byte_out), 32'h10);

        // Frame gap after a single byte, no repeat
        g0 = n_gap;
        send(8'h01, 1'b1, 1'b1);
        tick(GAP + 20);
        check("gap_byte", 32'(byte_out), 32'h01);
        check("gap_pulse_once", 32'(n_gap - g0), 32'd1);
        check_rng("gap_delay", gap_cyc - upd_cyc, GAP - 2, GAP + 2);
        tick(GAP + GAP / 2);
        check("gap_no_repeat", 32'(n_gap - g0), 32'd1);

        // Closely spaced bytes: no gap
        g0 = n_gap;
        send(8'h11, 1'b0, 1'b1);
        tick(100);
        send(8'h22, 1'b0, 1'b1);
        tick(100);
        send(8'h33, 1'b0, 1'b1);
        tick(GAP / 2);
        check("spaced_no_gap", 32'(n_gap - g0), 32'd0);
        check("spaced_byte", 32'(byte_out), 32'h33);

        // DE abort mid-byte, also disarms the gap
        u1 = n_upd;
        rx = 1'b0;
        tick(3 * BIT);
        DE = 1'b1;
        tick(5);
        check("de_forces_idle", 32'(busy), 32'h0);
        rx = 1'b1;
        tick(8 * BIT);
        DE = 1'b0;
        tick(2 * BIT);
        check("de_no_upd", 32'(n_upd - u1), 32'd0);
        check("de_still_idle", 32'(busy), 32'h0);
        check("de_byte_kept", 32'(byte_out), 32'h33);
        tick(GAP + 20);
        check("de_gap_disarmed", 32'(n_gap - g0), 32'd0);

        // Reset abort mid-byte
        rx = 1'b0;
        tick(4 * BIT);
        reset = 1'b1;
        tick(2);
        check("rstab_byte_out", 32'(byte_out), 32'h00);
        check("rstab_err_cnt", 32'(err_cnt), 32'h0);
        check("rstab_busy", 32'(busy), 32'h0);
        check("rstab_update_rx", 32'(update_rx), 32'h0);
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        u1 = n_upd;
        send(8'h5A, 1'b0, 1'b1);
        tick(10);
        check("post_reset_byte", 32'(byte_out), 32'h5A);
        check("post_reset_upd", 32'(n_upd - u1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
